// File: rtl/hilbert_lane_delay_align.sv
// hilbert_lane_delay_align: multi-lane whole-sample delay with glitch-free switching on a word boundary.
module hilbert_lane_delay_align #(
    parameter int LANES    = 4,
    parameter int SAMPLE_W = 16,
    parameter int DELAY_W  = 5
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [LANES*SAMPLE_W-1:0] s_data,
    input  logic                      s_valid,
    input  logic [DELAY_W-1:0]        delay_value,
    input  logic                      delay_load,
    output logic [LANES*SAMPLE_W-1:0] m_data,
    output logic                      m_valid,
    output logic [DELAY_W-1:0]        delay_active,
    output logic [LANES*8-1:0]        mux_select,
    output logic                      busy
);
    localparam int MAX_DELAY = (1 << DELAY_W) - 1;
    localparam int HW        = (MAX_DELAY + LANES - 1) / LANES;
    localparam int HIST      = HW * LANES;
    localparam int WIN       = HIST + LANES;

    typedef enum logic {RUN, HOLD} state_t;

    state_t                      r_state;
    logic [SAMPLE_W-1:0]         r_hist [HIST];
    logic [LANES*SAMPLE_W-1:0]   r_mdata;
    logic                        r_mvalid;
    logic [DELAY_W-1:0]          r_delay;
    logic [DELAY_W-1:0]          r_pending;
    logic [LANES*8-1:0]          r_mux;
    logic                        r_busy;

    logic [SAMPLE_W-1:0]         w_win [WIN];
    logic [DELAY_W-1:0]          w_d;
    logic [LANES*8-1:0]          w_sel;
    logic [LANES*SAMPLE_W-1:0]   w_out;

    // A word arriving in HOLD is the switch word and already uses the pending delay.
    assign w_d = (r_state == HOLD) ? r_pending : r_delay;

    always_comb begin
        for (int i = 0; i < HIST; i++) w_win[i] = r_hist[i];
        for (int l = 0; l < LANES; l++) w_win[HIST+l] = s_data[l*SAMPLE_W +: SAMPLE_W];
    end

    always_comb begin
        w_sel = '0;
        w_out = '0;
        for (int j = 0; j < LANES; j++) begin
            w_sel[j*8 +: 8] = 8'(HIST + j) - 8'(w_d);
            for (int k = 0; k < WIN; k++)
                if (w_sel[j*8 +: 8] == 8'(k)) w_out[j*SAMPLE_W +: SAMPLE_W] = w_win[k];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < HIST; i++) r_hist[i] <= '0;
            for (int j = 0; j < LANES; j++) r_mux[j*8 +: 8] <= 8'(HIST + j);
            r_mdata   <= '0;
            r_mvalid  <= 1'b0;
            r_delay   <= '0;
            r_pending <= '0;
            r_busy    <= 1'b0;
            r_state   <= RUN;
        end else begin
            r_mvalid <= s_valid;
            if (s_valid) begin
                for (int i = 0; i < HIST; i++) r_hist[i] <= w_win[i+LANES];
                r_mdata <= w_out;
            end
            if (r_state == RUN) begin
                if (delay_load) begin
                    r_pending <= delay_value;
                    r_busy    <= 1'b1;
                    r_state   <= HOLD;
                end
            end else if (s_valid) begin
                r_delay <= r_pending;
                r_mux   <= w_sel;
                r_busy  <= 1'b0;
                r_state <= RUN;
            end
        end
    end

    assign m_data       = r_mdata;
    assign m_valid      = r_mvalid;
    assign delay_active = r_delay;
    assign mux_select   = r_mux;
    assign busy         = r_busy;
endmodule

// File: tb/tb_hilbert_lane_delay_align.sv
// tb_hilbert_lane_delay_align: directed ramp checks of delay, switching, gaps and reset.
module tb_hilbert_lane_delay_align;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic [4:0]  delay_value = '0;
    logic        delay_load = 1'b0;
    logic [63:0] m_data;
    logic        m_valid;
    logic [4:0]  delay_active;
    logic [31:0] mux_select;
    logic        busy;
    int checks = 0;
    int errors = 0;

    hilbert_lane_delay_align dut (
        .aclk(aclk), .aresetn(aresetn), .s_data(s_data), .s_valid(s_valid),
        .delay_value(delay_value), .delay_load(delay_load), .m_data(m_data),
        .m_valid(m_valid), .delay_active(delay_active), .mux_select(mux_select), .busy(busy)
    );

    always #5 aclk = ~aclk;

    function automatic logic [63:0] ramp(input int w, input int d);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) r[j*16 +: 16] = (4*w + j - d < 0) ? 16'd0 : 16'(4*w + j - d);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] d, input logic ld, input logic [4:0] dv);
        s_valid = v;
        s_data = d;
        delay_load = ld;
        delay_value = dv;
        @(posedge aclk);
        #1;
        delay_load = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        cyc(1'b0, '0, 1'b0, '0);
        aresetn = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mvalid"}, 64'(m_valid), 64'd0);
        chk({tag, "_mdata"}, m_data, 64'd0);
        chk({tag, "_delay"}, 64'(delay_active), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_mux"}, 64'(mux_select), 64'h2322_2120);
    endtask

    initial begin
        cyc(1'b0, '0, 1'b0, '0);
        do_reset();
        cyc(1'b0, '0, 1'b0, '0);
        chk_reset("reset");

        for (int w = 0; w < 12; w++) begin
            cyc(1'b1, ramp(w, 0), 1'b0, '0);
            chk("d0_ramp", m_data, ramp(w, 0));
            chk("d0_mvalid", 64'(m_valid), 64'd1);
        end
        chk("d0_w11_const", m_data, 64'h002F_002E_002D_002C);

        cyc(1'b1, ramp(12, 0), 1'b0, '0);
        cyc(1'b1, ramp(13, 0), 1'b0, '0);
        cyc(1'b1, ramp(14, 0), 1'b1, 5'd5);
        chk("load_word_old_delay", m_data, ramp(14, 0));
        chk("busy_after_load", 64'(busy), 64'd1);
        chk("delay_before_apply", 64'(delay_active), 64'd0);
        cyc(1'b1, ramp(15, 0), 1'b0, '0);
        chk("switch_word", m_data, 64'h003A_0039_0038_0037);
        chk("busy_after_apply", 64'(busy), 64'd0);
        chk("delay_applied", 64'(delay_active), 64'd5);
        chk("mux_d5", 64'(mux_select), 64'h1E1D_1C1B);
        for (int w = 16; w <= 20; w++) begin
            cyc(1'b1, ramp(w, 0), 1'b0, '0);
            chk("d5_ramp", m_data, ramp(w, 5));
        end
        chk("d5_w20_const", m_data, 64'h004E_004D_004C_004B);

        do_reset();
        cyc(1'b0, '0, 1'b1, 5'd31);
        chk("d31_busy", 64'(busy), 64'd1);
        for (int w = 0; w <= 10; w++) begin
            cyc(1'b1, ramp(w, 0), 1'b0, '0);
            if (w == 7) chk("d31_w7_zero", m_data, 64'd0);
            if (w == 8) chk("d31_w8_first", m_data, 64'h0004_0003_0002_0001);
        end
        chk("d31_w10", m_data, 64'h000C_000B_000A_0009);
        chk("d31_mux", 64'(mux_select), 64'h0403_0201);
        chk("d31_delay", 64'(delay_active), 64'd31);

        do_reset();
        for (int w = 0; w < 6; w++) cyc(1'b1, ramp(w, 0), 1'b0, '0);
        cyc(1'b1, ramp(6, 0), 1'b1, 5'd5);
        chk("gap_load_word", m_data, ramp(6, 0));
        cyc(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 5'd9);
        chk("gap_mvalid0", 64'(m_valid), 64'd0);
        chk("gap_hold_data", m_data, ramp(6, 0));
        chk("gap_busy_hold", 64'(busy), 64'd1);
        cyc(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, '0);
        chk("gap_mvalid0b", 64'(m_valid), 64'd0);
        cyc(1'b1, ramp(7, 0), 1'b0, '0);
        chk("gap_switch", m_data, 64'h001A_0019_0018_0017);
        chk("gap_mvalid1", 64'(m_valid), 64'd1);
        chk("gap_delay5", 64'(delay_active), 64'd5);
        chk("gap_busy_clr", 64'(busy), 64'd0);
        cyc(1'b0, '0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, '0);
        chk("gap_held2", m_data, 64'h001A_0019_0018_0017);
        cyc(1'b1, ramp(8, 0), 1'b0, '0);
        chk("gap_after", m_data, 64'h001E_001D_001C_001B);
        chk("gap_second_load_ignored", 64'(delay_active), 64'd5);

        cyc(1'b0, '0, 1'b1, 5'd12);
        chk("hold_busy", 64'(busy), 64'd1);
        do_reset();
        chk_reset("midreset");
        for (int w = 0; w < 4; w++) begin
            cyc(1'b1, ramp(w, 0), 1'b0, '0);
            chk("post_reset_d0", m_data, ramp(w, 0));
            chk("post_reset_delay", 64'(delay_active), 64'd0);
            chk("post_reset_busy", 64'(busy), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilbert_lane_delay_align.md
# hilbert_lane_delay_align

Parametrised multi-lane sample-delay aligner for the TX DSP core. It sits in front of the Hilbert filter path and delays a parallel stream of LANES samples per clock by a programmable whole-sample delay, 0 to 2^DELAY_W-1 samples. It holds a sample history and per-lane mux selects, and it switches delay glitch-free on a word boundary. It also reports the applied per-lane mux selects as status.

## Interface
- LANES, 4: samples per clock word; lane 0 is the earliest sample in time.
- SAMPLE_W, 16: bits per sample.
- DELAY_W, 5: delay width; MAX_DELAY = 2^DELAY_W-1.
- HW, derived = ceil(MAX_DELAY/LANES): number of history words. Constraint: (HW+1)*LANES ≤ 256.
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_data  in  LANES*SAMPLE_W  input word; lane j occupies bits [j*SAMPLE_W +: SAMPLE_W].
- s_valid  in  1  input word qualifier.
- delay_value  in  DELAY_W  requested delay in samples.
- delay_load  in  1  single-cycle request to apply delay_value.
- m_data  out  LANES*SAMPLE_W  delayed word.
- m_valid  out  1  output qualifier.
- delay_active  out  DELAY_W  delay currently applied.
- mux_select  out  LANES*8  per-lane window index currently applied; lane j occupies bits [j*8 +: 8].
- busy  out  1  high while a delay change is pending.

## Operation
- Window W is (HW+1)*LANES samples. The current s_data lane l sits at index HW*LANES+l. History word h (h=1 is the most recent accepted word) lane l sits at index (HW-h)*LANES+l.
- With D = delay_active, output lane j = W[HW*LANES + j - D]. The stored mux_select for lane j = HW*LANES + j - D.
- History shifts by one word only on cycles with s_valid=1. With s_valid=0, history, m_data and delay state are held.
- FSM states:
  - RUN: delay_load=1 latches delay_value into pending, sets busy=1 and moves to HOLD.
  - HOLD: delay_load is ignored. On the next s_valid=1 cycle, that same word is processed with the pending delay; delay_active and mux_select update, busy clears, and the FSM returns to RUN.
- Discontinuity at a delay switch is allowed; duplicated or skipped samples are not corrected.
- Reset values:
  - history all zero, so samples delayed from before reset read as 0
  - m_data=0, m_valid=0
  - delay_active=0, mux_select lane j = HW*LANES+j
  - busy=0, FSM state RUN, pending=0
- Reset mid-operation returns every item above to its reset value on the next edge and drops any pending load.

## Timing
- Latency is 1 cycle: s_valid at edge t gives m_valid=1 after edge t, with m_data computed from s_data at t plus history before t. m_valid is s_valid delayed by 1 cycle, with no other gating.
- A delay change takes effect on the first s_valid word strictly after the delay_load cycle. A delay_load coincident with s_valid in RUN does not affect that word.
- m_data and all status outputs are registered; there is no combinational path from inputs to outputs.
- busy asserts the cycle after delay_load and deasserts the cycle after the applying s_valid word.
- No backpressure; the block accepts one word every cycle.

## Test plan
Defaults are LANES=4, SAMPLE_W=16, DELAY_W=5, HW=8. The ramp stimulus drives global sample n with value n; word w carries 4w..4w+3.
- Reset, then idle → m_valid=0, m_data=0, delay_active=0, busy=0, mux_select lanes = {35,34,33,32} (lane 3 down to lane 0).
- D=0, ramp with continuous s_valid → each m_data equals the previous-cycle s_data; word w=10 outputs {43,42,41,40}.
- Load D=5 during the ramp, then stream → after the switch word, output lane j of word w = 4w+j-5, so w=20 gives {78,77,76,75}; mux_select = {30,29,28,27}; busy high for exactly the load-to-apply window.
- Load D=31 after reset, then ramp from n=0 → outputs for n<31 are 0; word w=10 gives {12,11,10,9}; mux_select lane 0 = 1.
- Run the D=5 ramp with s_valid toggling 1,0,0,1, plus a second delay_load while busy → m_valid follows s_valid with 1-cycle lag; sample values unchanged by the gaps; the second load is ignored.
- Assert aresetn=0 for one cycle while in HOLD with D=5 active → all outputs return to reset values, pending is discarded, and the next stream runs with D=0.
